// File: rtl/v_issue_wb_if.sv
// Issue/writeback bundle: instruction handshake, VRF read/write ports and ALU drive/result.
// slave = sequencer side, master = environment (decoder, VRF, ALU).
interface v_issue_wb_if #(
  parameter int VALUOP_DW = 5,
  parameter int VREG_DW   = 512,
  parameter int VREG_AW   = 5
);
  logic                 inst_valid_i;
  logic                 inst_ready_o;
  logic [VALUOP_DW-1:0] inst_opcode_i;
  logic [VREG_AW-1:0]   inst_vs1_i;
  logic [VREG_AW-1:0]   inst_vs2_i;
  logic [VREG_AW-1:0]   inst_vd_i;
  logic                 inst_wen_i;
  logic [VREG_AW-1:0]   vrf_raddr1_o;
  logic [VREG_DW-1:0]   vrf_rdata1_i;
  logic [VREG_AW-1:0]   vrf_raddr2_o;
  logic [VREG_DW-1:0]   vrf_rdata2_i;
  logic [VALUOP_DW-1:0] valu_opcode_o;
  logic [VREG_DW-1:0]   operand_v1_o;
  logic [VREG_DW-1:0]   operand_v2_o;
  logic [VREG_DW-1:0]   valu_result_i;
  logic                 vrf_wen_o;
  logic [VREG_AW-1:0]   vrf_waddr_o;
  logic [VREG_DW-1:0]   vrf_wdata_o;
  logic                 busy_o;

  modport slave (
    input  inst_valid_i, inst_opcode_i, inst_vs1_i, inst_vs2_i, inst_vd_i, inst_wen_i,
           vrf_rdata1_i, vrf_rdata2_i, valu_result_i,
    output inst_ready_o, vrf_raddr1_o, vrf_raddr2_o, valu_opcode_o, operand_v1_o,
           operand_v2_o, vrf_wen_o, vrf_waddr_o, vrf_wdata_o, busy_o
  );

  modport master (
    output inst_valid_i, inst_opcode_i, inst_vs1_i, inst_vs2_i, inst_vd_i, inst_wen_i,
           vrf_rdata1_i, vrf_rdata2_i, valu_result_i,
    input  inst_ready_o, vrf_raddr1_o, vrf_raddr2_o, valu_opcode_o, operand_v1_o,
           operand_v2_o, vrf_wen_o, vrf_waddr_o, vrf_wdata_o, busy_o
  );
endinterface

// File: rtl/v_issue_wb.sv
// Vector issue/writeback sequencer: E stage drives the combinational ALU, W stage writes the VRF.
// Latency: ALU driven 1 cycle after accept, VRF write 2 cycles after (divides: DIV_LAT+1).
// Backpressure: inst_ready_o drops only while a divide occupies E and has not finished.
module v_issue_wb #(
  parameter int VALUOP_DW = 5,
  parameter int VREG_DW   = 512,
  parameter int VREG_AW   = 5,
  parameter int DIV_LAT   = 4
) (
  input  logic         clk,
  input  logic         rst,
  v_issue_wb_if.slave  bus
);
  localparam logic [VALUOP_DW-1:0] OP_NOP    = '0;
  localparam logic [VALUOP_DW-1:0] OP_VDIV16 = VALUOP_DW'(3);
  localparam logic [VALUOP_DW-1:0] OP_VDIV32 = VALUOP_DW'(7);
  localparam int                   CW        = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0]        CNT_LAST  = CW'(DIV_LAT - 1);

  logic                 e_valid;
  logic [VALUOP_DW-1:0] e_op;
  logic [VREG_DW-1:0]   e_v1;
  logic [VREG_DW-1:0]   e_v2;
  logic [VREG_AW-1:0]   e_vd;
  logic                 e_wen;
  logic [CW-1:0]        e_cnt;

  logic                 w_valid;
  logic [VREG_AW-1:0]   w_vd;
  logic [VREG_DW-1:0]   w_data;
  logic                 w_wen;

  logic                 e_is_div;
  logic                 e_done;
  logic                 ready;
  logic                 accept;
  logic [VREG_DW-1:0]   fwd_v1;
  logic [VREG_DW-1:0]   fwd_v2;

  always_comb begin
    e_is_div = (e_op == OP_VDIV16) || (e_op == OP_VDIV32);
    e_done   = e_valid && (!e_is_div || (e_cnt == CNT_LAST));
    ready    = !e_valid || e_done;
    accept   = bus.inst_valid_i && ready;
  end

  // Youngest producer wins: E result is newer than the W entry, which is newer than the VRF.
  always_comb begin
    if (e_valid && e_wen && (e_vd == bus.inst_vs1_i))
      fwd_v1 = bus.valu_result_i;
    else if (w_valid && w_wen && (w_vd == bus.inst_vs1_i))
      fwd_v1 = w_data;
    else
      fwd_v1 = bus.vrf_rdata1_i;

    if (e_valid && e_wen && (e_vd == bus.inst_vs2_i))
      fwd_v2 = bus.valu_result_i;
    else if (w_valid && w_wen && (w_vd == bus.inst_vs2_i))
      fwd_v2 = w_data;
    else
      fwd_v2 = bus.vrf_rdata2_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid <= 1'b0;
      e_op    <= '0;
      e_v1    <= '0;
      e_v2    <= '0;
      e_vd    <= '0;
      e_wen   <= 1'b0;
      e_cnt   <= '0;
      w_valid <= 1'b0;
      w_vd    <= '0;
      w_data  <= '0;
      w_wen   <= 1'b0;
    end else begin
      if (accept) begin
        e_valid <= 1'b1;
        e_op    <= bus.inst_opcode_i;
        e_vd    <= bus.inst_vd_i;
        e_wen   <= bus.inst_wen_i && (bus.inst_opcode_i != OP_NOP);
        e_cnt   <= '0;
        e_v1    <= fwd_v1;
        e_v2    <= fwd_v2;
      end else if (e_done) begin
        e_valid <= 1'b0;
      end else if (e_valid) begin
        e_cnt <= e_cnt + 1'b1;
      end

      w_valid <= e_done;
      if (e_done) begin
        w_data <= bus.valu_result_i;
        w_vd   <= e_vd;
        w_wen  <= e_wen;
      end
    end
  end

  assign bus.inst_ready_o  = ready;
  assign bus.vrf_raddr1_o  = bus.inst_vs1_i;
  assign bus.vrf_raddr2_o  = bus.inst_vs2_i;
  assign bus.valu_opcode_o = e_valid ? e_op : OP_NOP;
  assign bus.operand_v1_o  = e_valid ? e_v1 : '0;
  assign bus.operand_v2_o  = e_valid ? e_v2 : '0;
  assign bus.vrf_wen_o     = w_valid && w_wen;
  assign bus.vrf_waddr_o   = w_valid ? w_vd : '0;
  assign bus.vrf_wdata_o   = w_valid ? w_data : '0;
  assign bus.busy_o        = e_valid || w_valid;
endmodule

// File: tb/tb_v_issue_wb.sv
// Bench for v_issue_wb: provides the VRF and ALU around the DUT and checks every VRF write
// against an in-order architectural model through a scoreboard queue.
module tb_v_issue_wb;
  localparam int OW = 5;
  localparam int DW = 512;
  localparam int AW = 5;
  localparam int DL = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  v_issue_wb_if #(.VALUOP_DW(OW), .VREG_DW(DW), .VREG_AW(AW)) bus ();
  v_issue_wb #(.VALUOP_DW(OW), .VREG_DW(DW), .VREG_AW(AW), .DIV_LAT(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  wb_t exp_q[$];
  logic [DW-1:0] arch [32];
  logic [DW-1:0] snap [32];

  // Environment ALU: lane-wise ops for the named opcodes, an arbitrary mix for the rest.
  function automatic logic [DW-1:0] alu(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      5'd0: r = '0;
      5'd2: for (int i = 0; i < DW/16; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
      5'd3: for (int i = 0; i < DW/16; i++)
              r[i*16 +: 16] = (b[i*16 +: 16] == 16'd0) ? 16'hffff : a[i*16 +: 16] / b[i*16 +: 16];
      5'd4: for (int i = 0; i < DW/16; i++)
              r[i*16 +: 16] = (a[i*16 +: 16] > b[i*16 +: 16]) ? a[i*16 +: 16] : b[i*16 +: 16];
      5'd6: for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
      5'd7: for (int i = 0; i < DW/32; i++)
              r[i*32 +: 32] = (b[i*32 +: 32] == 32'd0) ? 32'hffffffff : a[i*32 +: 32] / b[i*32 +: 32];
      default: r = a ^ (b << op) ^ DW'(op);
    endcase
    return r;
  endfunction

  always_comb bus.valu_result_i = alu(bus.valu_opcode_o, bus.operand_v1_o, bus.operand_v2_o);

  // VRF: combinational read, write at clock edge; bench preload shares the write port.
  logic [DW-1:0] vrf [32];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_idx = '0;
  logic [DW-1:0] pl_val = '0;
  always @(posedge clk) begin
    if (pl_en) vrf[pl_idx] <= pl_val;
    if (bus.vrf_wen_o) vrf[bus.vrf_waddr_o] <= bus.vrf_wdata_o;
  end
  assign bus.vrf_rdata1_i = vrf[bus.vrf_raddr1_o];
  assign bus.vrf_rdata2_i = vrf[bus.vrf_raddr2_o];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  task automatic preload(input logic [AW-1:0] idx, input logic [DW-1:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    arch[idx] = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // In-order architectural effect of one accepted instruction.
  task automatic model_accept(input logic [OW-1:0] op, input logic [AW-1:0] s1,
                              input logic [AW-1:0] s2, input logic [AW-1:0] d, input logic w);
    wb_t e;
    if (w && op != '0) begin
      e.addr = d;
      e.data = alu(op, arch[s1], arch[s2]);
      arch[d] = e.data;
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [OW-1:0] op, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                      input logic [AW-1:0] d, input logic w);
    logic r;
    logic done;
    done = 1'b0;
    bus.inst_valid_i  = 1'b1;
    bus.inst_opcode_i = op;
    bus.inst_vs1_i    = s1;
    bus.inst_vs2_i    = s2;
    bus.inst_vd_i     = d;
    bus.inst_wen_i    = w;
    for (int t = 0; t < 50; t++) begin
      #1 r = bus.inst_ready_o;
      @(posedge clk);
      if (r) begin
        model_accept(op, s1, s2, d, w);
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) fail("send_timeout");
    @(negedge clk);
    bus.inst_valid_i = 1'b0;
  endtask

  task automatic drain();
    logic idle;
    idle = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (!bus.busy_o) begin
        idle = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!idle) fail("drain_timeout");
  endtask

  // Scoreboard monitor.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (bus.vrf_wen_o) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          fail("wb_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("wb_addr", DW'(bus.vrf_waddr_o), DW'(e.addr));
          chk("wb_data", bus.vrf_wdata_o, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] ops [8];
    int w0;
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd9};
    bus.inst_valid_i  = 1'b0;
    bus.inst_opcode_i = '0;
    bus.inst_vs1_i    = '0;
    bus.inst_vs2_i    = '0;
    bus.inst_vd_i     = '0;
    bus.inst_wen_i    = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", DW'(bus.inst_ready_o), DW'(1));
    chk("rst_opcode", DW'(bus.valu_opcode_o), '0);
    chk("rst_operand", bus.operand_v1_o | bus.operand_v2_o, '0);
    chk("rst_wen", DW'(bus.vrf_wen_o), '0);
    chk("rst_waddr", DW'(bus.vrf_waddr_o), '0);
    chk("rst_busy", DW'(bus.busy_o), '0);

    for (int i = 0; i < 32; i++)
      preload(AW'(i), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    preload(5'd1, {16{32'd5}});
    preload(5'd2, {16{32'd7}});
    preload(5'd10, {16{32'd100}});
    preload(5'd11, {16{32'd7}});

    // Single VADD32
    send(5'd6, 5'd1, 5'd2, 5'd3, 1'b1);
    chk("add_opcode_c1", DW'(bus.valu_opcode_o), DW'(6));
    @(negedge clk);
    chk("add_wen_c2", DW'(bus.vrf_wen_o), DW'(1));
    chk("add_waddr_c2", DW'(bus.vrf_waddr_o), DW'(3));
    chk("add_wdata_c2", bus.vrf_wdata_o, {16{32'd12}});
    drain();

    // Back-to-back dependence: E forward then W forward, no stall
    fork
      begin
        send(5'd2, 5'd1, 5'd2, 5'd4, 1'b1);
        send(5'd4, 5'd4, 5'd1, 5'd5, 1'b1);
        send(5'd2, 5'd4, 5'd4, 5'd6, 1'b1);
      end
      begin
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
          chk("dep_wen", DW'(bus.vrf_wen_o), DW'(k >= 2 && k <= 4));
          if (k >= 2 && k <= 4) chk("dep_waddr", DW'(bus.vrf_waddr_o), DW'(k + 2));
          @(negedge clk);
        end
      end
    join
    drain();

    // Divide occupancy, younger instruction waiting and consuming the quotient via E forward
    fork
      begin
        send(5'd7, 5'd10, 5'd11, 5'd12, 1'b1);
        send(5'd6, 5'd12, 5'd11, 5'd13, 1'b1);
      end
      begin
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
          chk("div_opcode", DW'(bus.valu_opcode_o), DW'(7));
          chk("div_ready", DW'(bus.inst_ready_o), DW'(k == 4));
          @(negedge clk);
        end
        chk("div_wen_c5", DW'(bus.vrf_wen_o), DW'(1));
        chk("div_waddr_c5", DW'(bus.vrf_waddr_o), DW'(12));
        chk("div_wdata_c5", bus.vrf_wdata_o, {16{32'd14}});
      end
    join
    drain();

    // NOP and non-writing VADD32: no writes, busy cycles 1-3
    w0 = wr_cnt;
    fork
      begin
        send(5'd0, 5'd1, 5'd2, 5'd7, 1'b1);
        send(5'd6, 5'd1, 5'd2, 5'd8, 1'b0);
      end
      begin
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
          chk("nowr_busy", DW'(bus.busy_o), DW'(k <= 3));
          chk("nowr_wen", DW'(bus.vrf_wen_o), '0);
          @(negedge clk);
        end
      end
    join
    chk("nowr_count", DW'(wr_cnt), DW'(w0));

    // Reset in the middle of a divide drops it
    drain();
    snap = arch;
    send(5'd7, 5'd10, 5'd11, 5'd14, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    arch = snap;
    w0 = wr_cnt;
    chk("rstdiv_ready", DW'(bus.inst_ready_o), DW'(1));
    chk("rstdiv_busy", DW'(bus.busy_o), '0);
    repeat (8) @(negedge clk);
    chk("rstdiv_nowrite", DW'(wr_cnt), DW'(w0));

    // Randomized stream with heavy register reuse
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(ops[$urandom_range(0, 7)], AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0));
    end
    drain();
    repeat (2) @(negedge clk);
    chk("final_queue_empty", DW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
